// File: rtl/cbda_timer_ctl.sv
// cbda_timer_ctl: periodic timer sequencer driving an external 8-bit down
// counter (LD/EN/CAI/D) and consuming its terminal count (CAO).
// Each accepted START loads RLD into the counter and produces one TICK every
// RLD+1 clocks, for REPS periods, or forever when REPS is 0.
// Optional build macro: CBDA_TIMER_PAUSE_EN adds a PAUSE input that freezes
// the counter while in RUN.
module cbda_timer_ctl #(
  parameter int WIDTH = 8,
  parameter int REPW  = 8
) (
  input  logic             CLK,
  input  logic             CD,
  input  logic             START,
  input  logic             STOP,
`ifdef CBDA_TIMER_PAUSE_EN
  input  logic             PAUSE,
`endif
  input  logic [WIDTH-1:0] RLD,
  input  logic [REPW-1:0]  REPS,
  input  logic             CAO,
  output logic             LD,
  output logic             EN,
  output logic             CAI,
  output logic [WIDTH-1:0] DOUT,
  output logic             TICK,
  output logic [REPW-1:0]  PCNT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [REPW-1:0] rep_q;      // periods still to go; 0 means free-run
  logic            en_q;
  logic            pause_req;
  logic            accept;     // START taken in IDLE this edge
  logic            cao_ev;     // a period completes at this edge
  logic            last_rep;   // the completing period is the final one

`ifdef CBDA_TIMER_PAUSE_EN
  assign pause_req = PAUSE;
`else
  assign pause_req = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && START && !STOP;

  // CAO only counts while the counter is actually enabled, so a paused
  // counter never reloads or advances the period count.
  assign cao_ev   = (state_q == S_RUN) && en_q && CAO;
  assign last_rep = cao_ev && (rep_q == REPW'(1));

  // Combinational strobes: load in LOAD, reload on terminal count in RUN.
  assign LD   = (state_q == S_LOAD) || cao_ev;
  assign EN   = en_q;
  assign CAI  = en_q;
  assign BUSY = (state_q == S_LOAD) || (state_q == S_RUN);

  // Next-state selection; STOP always wins over START and over completion.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = STOP ? S_IDLE : S_RUN;
      S_RUN:   if (STOP || last_rep) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, enable, shadow registers, period counter and status pulses.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      DOUT    <= '0;
      rep_q   <= '0;
      PCNT    <= '0;
      TICK    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Entering RUN from LOAD always enables; PAUSE only gates RUN itself.
      en_q    <= (state_d == S_RUN) && !((state_q == S_RUN) && pause_req);
      TICK    <= cao_ev;
      DONE    <= last_rep && !STOP;
      if (accept) begin
        DOUT  <= RLD;
        rep_q <= REPS;
        PCNT  <= '0;
      end else if (cao_ev) begin
        PCNT <= PCNT + 1'b1;
        if (rep_q != '0) rep_q <= rep_q - 1'b1;
      end
    end
  end

endmodule
